// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake for uart_tx_fifo: producer drives data/valid, FIFO returns ready.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format fed by a circular transmit FIFO.
// Frames run back to back while the FIFO holds words; TX idles high otherwise.
module uart_tx_fifo #(
  parameter int CLOCK_PER_BAUD  = 5208,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     CLOCK_50M,
  input  logic                     RESET,
  uart_tx_fifo_if.slave            wr,
  output logic                     TX,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
  localparam int BW = $clog2(CLOCK_PER_BAUD);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCK_PER_BAUD - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD_PARITY = (PARITY_MODE == 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t r_state, w_state_next;

  logic [DATA_BITS-1:0]       r_mem [1 << FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count, w_count_next;
  logic                       r_ready;
  logic [BW-1:0]              r_baud;
  logic [3:0]                 r_bit_idx;
  logic                       r_stop_idx;
  logic [DATA_BITS-1:0]       r_shift;
  logic                       r_parity;
  logic                       r_tx;

  logic                 w_push, w_pop, w_bit_end, w_tx_next;
  logic [DATA_BITS-1:0] w_head;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_push      = wr.tx_valid & r_ready;
  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign wr.tx_ready = r_ready;
  assign TX          = r_tx;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);
  assign fifo_count  = r_count;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      S_START:
        if (w_bit_end) w_state_next = S_DATA;
      S_DATA:
        if (w_bit_end && (r_bit_idx == BIT_LAST))
          w_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY:
        if (w_bit_end) w_state_next = S_STOP;
      S_STOP:
        if (w_bit_end && (r_stop_idx == STOP_LAST)) begin
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      default: w_state_next = S_IDLE;
    endcase
  end

  // TX is registered; the DATA level looks one bit ahead when the shift happens at this edge.
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
      S_PARITY: w_tx_next = r_parity;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge CLOCK_50M) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLOCK_50M) begin
    if (w_push && !RESET) r_mem[r_wr_ptr] <= wr.tx_data;
  end

  always_ff @(posedge CLOCK_50M) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_ready <= (w_count_next != FULL);
      r_tx    <= w_tx_next;
      r_baud  <= (r_state == S_IDLE || w_bit_end) ? '0 : r_baud + 1'b1;
      if (w_pop) begin
        r_shift    <= w_head;
        r_parity   <= (^w_head) ^ ODD_PARITY;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
      end else if (w_bit_end) begin
        if (r_state == S_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 4'd1;
        end
        if (r_state == S_STOP) r_stop_idx <= ~r_stop_idx;
      end
    end
  end
endmodule
